gather_wb: RTL and testbench
============================

// Module: gather_wb
// PURPOSE
//  Write-back stage downstream of the scatter/gather read engine. Accepts the gathered
//  read-data beats and buffers them in an internal FIFO. Issues one incrementing AXI-style
//  write burst per block to a contiguous write-back buffer at cfg_wb_addr, then raises done.
// PARAMETERS
//  AXI_DW      512  data width (bits) of input beats and write data
//  AXI_AW      64   address width
//  AXI_MIDW    4    write ID width
//  AXI_WID     0    write ID driven on wr_mid
//  BURST_LEN   32   beats per block = beats per write burst (power of 2, <=256)
//  FIFO_DEPTH  64   buffer depth in beats (power of 2, >= BURST_LEN)
// PORTS
//  axi_clk        in   1         clock (250MHz)
//  axi_rst        in   1         asynchronous reset, active-high
//  cfg_start      in   1         1-cycle start pulse
//  cfg_wb_addr    in   AXI_AW    write-back base address
//  cfg_blocknum   in   16        number of blocks (bursts) to write
//  in_valid       in   1         input beat valid
//  in_data        in   AXI_DW    input beat
//  in_ready       out  1         input beat accepted when in_valid&in_ready
//  wr_maddr       out  AXI_AW    burst address
//  wr_mlen        out  8         burst length-1 (BURST_LEN-1)
//  wr_msize       out  3         log2(AXI_DW/8)
//  wr_mid         out  AXI_MIDW  AXI_WID
//  wr_mwrite      out  1         address request valid
//  wr_saccept     in   1         address accepted when wr_mwrite&wr_saccept
//  wr_mdata       out  AXI_DW    write data
//  wr_mwstrb      out  AXI_DW/8  all ones
//  wr_mvalid      out  1         write data valid
//  wr_mlast       out  1         last beat of burst
//  wr_sready      in   1         data beat accepted when wr_mvalid&wr_sready
//  wr_sbvalid     in   1         write response valid (wr_mbready tied 1)
//  wr_sresp       in   2         write response, nonzero = error
//  done           out  1         level; all blocks written and responded
//  err            out  1         sticky; any nonzero wr_sresp since start
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, all counters 0; in_ready=0, wr_mwrite=0, wr_mvalid=0,
//   wr_mlast=0, done=0, err=0, wr_maddr=0. Reset mid-burst aborts silently; FIFO flushed.
//  FSM: IDLE -cfg_start-> (blocknum==0 ? DONE : WAIT); WAIT -fifo_cnt>=BURST_LEN-> ADDR;
//   ADDR -wr_saccept-> DATA; DATA -last beat accepted-> RESP;
//   RESP -wr_sbvalid-> (blk_cnt==blocknum-1 ? DONE : WAIT, blk_cnt++); DONE -cfg_start-> as IDLE.
//  cfg_start outside IDLE/DONE ignored. cfg_* sampled on accepted start; done/err cleared on it.
//  in_ready = !fifo_full & state!=IDLE & state!=DONE (combinational from registered count).
//   Beats offered in IDLE/DONE are not accepted.
//  Beats beyond blocknum*BURST_LEN stay in FIFO; flushed on next start.
//  FIFO: push and pop in same cycle leaves count unchanged; full push blocked by in_ready.
//   First-word-fall-through: wr_mdata = FIFO head, wr_mvalid = (state==DATA) & !empty.
//  wr_mlast=1 when beat_cnt==BURST_LEN-1 in DATA; beat_cnt wraps to 0 after last beat.
//  Address: base forced aligned (low log2(BURST_LEN*AXI_DW/8) bits zeroed); burst n at
//   base + n*BURST_LEN*AXI_DW/8, 64-bit modulo add; bursts never cross 4KB when burst<=4KB.
//  One burst outstanding; a response arriving before the last beat is still recorded (err).
//  done asserts the cycle after entering DONE; held until next accepted cfg_start.
// CONFIGURATION
//  GATHER_WB_PERF_EN defined: adds outputs perf_cycles[31:0] (cycles from start to done)
//   and perf_stall[31:0] (cycles wr_mvalid&!wr_sready); both saturate, clear on start.
//  Undefined: ports and counters absent; functionality otherwise identical.
// STRUCTURE
//  Package gather_wb_pkg: state enum (IDLE,WAIT,ADDR,DATA,RESP,DONE), RESP_OKAY=2'b00.
//  Sub-module gather_wb_fifo: sync FWFT FIFO, width AXI_DW, depth FIFO_DEPTH, count output.
// TESTING
//  blocknum=0, start -> done=1 two cycles later, no wr_mwrite ever.
//  blocknum=2, base 0x1000, 64 beats streamed -> bursts at 0x1000 and 0x1800, mlen=31,
//   data in order, mlast on beats 31/63, done=1.
//  wr_saccept delayed 10 cycles and wr_sready toggling 50% -> no beat lost/duplicated.
//  Upstream sends 100 beats while wr_sready=0 -> in_ready drops at 64 buffered, resumes after.
//  Second burst returns wr_sresp=2'b10 -> err=1 sticky, done=1, err cleared on next start.
//  axi_rst asserted mid-DATA -> all outputs reset values; restart completes 1 block correctly.

Source files
------------

// File: rtl/gather_wb_pkg.sv
// Shared types and constants for the gather_wb write-back stage.
package gather_wb_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      ADDR = 3'd2,
      DATA = 3'd3,
      RESP = 3'd4,
      DONE = 3'd5
   } state_e;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/gather_wb_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and synchronous flush.
module gather_wb_fifo #(
   parameter int W     = 512,
   parameter int DEPTH = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [W-1:0]               data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               data_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW:0]   count_q;

   always_ff @(posedge clk_i) begin
      if (push_i) mem[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign data_o  = mem[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign count_o = count_q;

endmodule

// File: rtl/gather_wb.sv
// Write-back stage: buffers gathered beats and writes one aligned burst per block.
// Optional GATHER_WB_PERF_EN adds saturating perf_cycles / perf_stall counters.
module gather_wb
   import gather_wb_pkg::*;
#(
   parameter int AXI_DW     = 512,
   parameter int AXI_AW     = 64,
   parameter int AXI_MIDW   = 4,
   parameter int AXI_WID    = 0,
   parameter int BURST_LEN  = 32,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                  axi_clk,
   input  logic                  axi_rst,
   input  logic                  cfg_start,
   input  logic [AXI_AW-1:0]     cfg_wb_addr,
   input  logic [15:0]           cfg_blocknum,
   input  logic                  in_valid,
   input  logic [AXI_DW-1:0]     in_data,
   output logic                  in_ready,
   output logic [AXI_AW-1:0]     wr_maddr,
   output logic [7:0]            wr_mlen,
   output logic [2:0]            wr_msize,
   output logic [AXI_MIDW-1:0]   wr_mid,
   output logic                  wr_mwrite,
   input  logic                  wr_saccept,
   output logic [AXI_DW-1:0]     wr_mdata,
   output logic [AXI_DW/8-1:0]   wr_mwstrb,
   output logic                  wr_mvalid,
   output logic                  wr_mlast,
   input  logic                  wr_sready,
   input  logic                  wr_sbvalid,
   input  logic [1:0]            wr_sresp,
`ifdef GATHER_WB_PERF_EN
   output logic [31:0]           perf_cycles,
   output logic [31:0]           perf_stall,
`endif
   output logic [2:0]            dbg_state,
   output logic                  done,
   output logic                  err
);

   localparam int BEAT_BYTES  = AXI_DW / 8;
   localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
   localparam int BCW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int CW          = $clog2(FIFO_DEPTH) + 1;
   localparam logic [AXI_AW-1:0] ALIGN_MASK = ~(AXI_AW'(BURST_BYTES - 1));
   localparam logic [AXI_AW-1:0] ADDR_STEP  = AXI_AW'(BURST_BYTES);

   state_e              state_q;
   logic [15:0]         blocknum_q;
   logic [15:0]         blk_cnt_q;
   logic [BCW-1:0]      beat_cnt_q;
   logic [AXI_AW-1:0]   wr_maddr_q;
   logic                wr_mwrite_q;
   logic                done_q;
   logic                err_q;
   logic                resp_seen_q;

   logic                fifo_empty;
   logic                fifo_full;
   logic [CW-1:0]       fifo_cnt;
   logic                start_acc;
   logic                push;
   logic                beat_fire;
   logic                beat_last;
   logic                busy;

   assign busy      = (state_q != IDLE) && (state_q != DONE);
   assign start_acc = cfg_start && !busy;
   assign in_ready  = !fifo_full && busy;
   assign push      = in_valid && in_ready;
   assign wr_mvalid = (state_q == DATA) && !fifo_empty;
   assign beat_last = (beat_cnt_q == BCW'(BURST_LEN - 1));
   assign beat_fire = wr_mvalid && wr_sready;
   assign wr_mlast  = (state_q == DATA) && beat_last;

   gather_wb_fifo #(
      .W     (AXI_DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (axi_clk),
      .rst_i   (axi_rst),
      .flush_i (start_acc),
      .push_i  (push),
      .data_i  (in_data),
      .pop_i   (beat_fire),
      .data_o  (wr_mdata),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_cnt)
   );

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         state_q     <= IDLE;
         blocknum_q  <= '0;
         blk_cnt_q   <= '0;
         beat_cnt_q  <= '0;
         wr_maddr_q  <= '0;
         wr_mwrite_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         resp_seen_q <= 1'b0;
      end else begin
         if (busy && wr_sbvalid && (wr_sresp != RESP_OKAY)) err_q <= 1'b1;
         if (beat_fire) beat_cnt_q <= beat_last ? '0 : beat_cnt_q + 1'b1;
         case (state_q)
            IDLE, DONE: begin
               done_q <= (state_q == DONE);
               if (cfg_start) begin
                  blocknum_q  <= cfg_blocknum;
                  blk_cnt_q   <= '0;
                  beat_cnt_q  <= '0;
                  resp_seen_q <= 1'b0;
                  wr_maddr_q  <= cfg_wb_addr & ALIGN_MASK;
                  done_q      <= 1'b0;
                  err_q       <= 1'b0;
                  state_q     <= (cfg_blocknum == 16'd0) ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (fifo_cnt >= CW'(BURST_LEN)) begin
                  wr_mwrite_q <= 1'b1;
                  state_q     <= ADDR;
               end
            end
            ADDR: begin
               if (wr_sbvalid) resp_seen_q <= 1'b1;
               if (wr_saccept) begin
                  wr_mwrite_q <= 1'b0;
                  state_q     <= DATA;
               end
            end
            DATA: begin
               // An early response is remembered so RESP does not wait for a second one.
               if (wr_sbvalid) resp_seen_q <= 1'b1;
               if (beat_fire && beat_last) state_q <= RESP;
            end
            RESP: begin
               if (wr_sbvalid || resp_seen_q) begin
                  resp_seen_q <= 1'b0;
                  if (blk_cnt_q == blocknum_q - 16'd1) begin
                     state_q <= DONE;
                  end else begin
                     blk_cnt_q  <= blk_cnt_q + 16'd1;
                     wr_maddr_q <= wr_maddr_q + ADDR_STEP;
                     state_q    <= WAIT;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef GATHER_WB_PERF_EN
   logic [31:0] perf_cycles_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge axi_clk or posedge axi_rst) begin
      if (axi_rst) begin
         perf_cycles_q <= '0;
         perf_stall_q  <= '0;
      end else if (start_acc) begin
         perf_cycles_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (busy && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 32'd1;
         if (wr_mvalid && !wr_sready && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stall  = perf_stall_q;
`endif

   assign wr_maddr  = wr_maddr_q;
   assign wr_mwrite = wr_mwrite_q;
   assign wr_mlen   = 8'(BURST_LEN - 1);
   assign wr_msize  = 3'($clog2(BEAT_BYTES));
   assign wr_mid    = AXI_MIDW'(AXI_WID);
   assign wr_mwstrb = '1;
   assign dbg_state = state_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_gather_wb.sv
// Directed bench for gather_wb: source/sink agent on negedge, scoreboard queues, final report.
module tb_gather_wb;

   localparam int DW = 512;
   localparam int AW = 64;
   localparam int BL = 32;

   typedef logic [DW-1:0] val_t;

   logic            axi_clk = 1'b0;
   logic            axi_rst = 1'b0;
   logic            cfg_start = 1'b0;
   logic [AW-1:0]   cfg_wb_addr = '0;
   logic [15:0]     cfg_blocknum = '0;
   logic            in_valid = 1'b0;
   logic [DW-1:0]   in_data = '0;
   logic            in_ready;
   logic [AW-1:0]   wr_maddr;
   logic [7:0]      wr_mlen;
   logic [2:0]      wr_msize;
   logic [3:0]      wr_mid;
   logic            wr_mwrite;
   logic            wr_saccept = 1'b0;
   logic [DW-1:0]   wr_mdata;
   logic [DW/8-1:0] wr_mwstrb;
   logic            wr_mvalid;
   logic            wr_mlast;
   logic            wr_sready = 1'b0;
   logic            wr_sbvalid = 1'b0;
   logic [1:0]      wr_sresp = 2'b00;
   logic [2:0]      dbg_state;
   logic            done;
   logic            err;

   gather_wb dut (
      .axi_clk      (axi_clk),
      .axi_rst      (axi_rst),
      .cfg_start    (cfg_start),
      .cfg_wb_addr  (cfg_wb_addr),
      .cfg_blocknum (cfg_blocknum),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .wr_maddr     (wr_maddr),
      .wr_mlen      (wr_mlen),
      .wr_msize     (wr_msize),
      .wr_mid       (wr_mid),
      .wr_mwrite    (wr_mwrite),
      .wr_saccept   (wr_saccept),
      .wr_mdata     (wr_mdata),
      .wr_mwstrb    (wr_mwstrb),
      .wr_mvalid    (wr_mvalid),
      .wr_mlast     (wr_mlast),
      .wr_sready    (wr_sready),
      .wr_sbvalid   (wr_sbvalid),
      .wr_sresp     (wr_sresp),
      .dbg_state    (dbg_state),
      .done         (done),
      .err          (err)
   );

   // clock / reset
   always #5 axi_clk = ~axi_clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] exp_q[$];
   logic [AW-1:0] exp_addr_q[$];

   int         src_left = 0;
   int         src_idx = 0;
   int         accepted_cnt = 0;
   int         acc_delay = 0;
   int         acc_wait = 0;
   int         rdy_mode = 1;
   int         beats_seen = 0;
   int         bursts_seen = 0;
   int         resp_timer = 0;
   int         bad_burst = -1;
   logic [1:0] bad_resp = 2'b10;
   int         mwrite_cycles = 0;

   task automatic check_eq(input string tag, input val_t act, input val_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] make_beat(input int idx);
      logic [DW-1:0] b;
      for (int k = 0; k < DW / 32; k++) b[k*32 +: 32] = {idx[15:0], 16'(k)};
      return b;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge axi_clk);
         #1;
      end
   endtask

   // source, address acceptor, data sink and response generator
   always @(negedge axi_clk) begin
      if (axi_rst) begin
         in_valid   = 1'b0;
         wr_saccept = 1'b0;
         wr_sready  = 1'b0;
         wr_sbvalid = 1'b0;
         wr_sresp   = 2'b00;
         acc_wait   = 0;
         resp_timer = 0;
      end else begin
         if (src_left > 0) begin
            in_valid = 1'b1;
            in_data  = make_beat(src_idx);
            if (in_ready) begin
               exp_q.push_back(in_data);
               src_idx++;
               src_left--;
               accepted_cnt++;
            end
         end else begin
            in_valid = 1'b0;
         end

         wr_saccept = 1'b0;
         if (wr_mwrite) begin
            mwrite_cycles++;
            if (acc_wait >= acc_delay) begin
               wr_saccept = 1'b1;
               acc_wait   = 0;
               if (exp_addr_q.size() == 0) check_eq("extra_burst", val_t'(1), val_t'(0));
               else check_eq("burst_addr", val_t'(wr_maddr), val_t'(exp_addr_q.pop_front()));
               check_eq("mlen", val_t'(wr_mlen), val_t'(31));
               check_eq("msize", val_t'(wr_msize), val_t'(6));
               check_eq("mid", val_t'(wr_mid), val_t'(0));
               check_eq("mwstrb", val_t'(wr_mwstrb), val_t'(64'hFFFF_FFFF_FFFF_FFFF));
            end else begin
               acc_wait++;
            end
         end

         case (rdy_mode)
            0:       wr_sready = 1'b0;
            1:       wr_sready = 1'b1;
            default: wr_sready = 1'($urandom_range(0, 1));
         endcase
         if (wr_mvalid && wr_sready) begin
            if (exp_q.size() == 0) check_eq("extra_beat", val_t'(1), val_t'(0));
            else check_eq("wdata", wr_mdata, exp_q.pop_front());
            check_eq("mlast", val_t'(wr_mlast), val_t'((beats_seen % BL) == BL - 1));
            beats_seen++;
            if ((beats_seen % BL) == 0) resp_timer = 3;
         end

         wr_sbvalid = 1'b0;
         wr_sresp   = 2'b00;
         if (resp_timer > 0) begin
            resp_timer--;
            if (resp_timer == 0) begin
               wr_sbvalid = 1'b1;
               wr_sresp   = (bursts_seen == bad_burst) ? bad_resp : 2'b00;
               bursts_seen++;
            end
         end
      end
   end

   task automatic start_run(input logic [AW-1:0] addr, input int nblk, input int nbeats,
                            input int bad);
      exp_q.delete();
      beats_seen    = 0;
      bursts_seen   = 0;
      mwrite_cycles = 0;
      accepted_cnt  = 0;
      bad_burst     = bad;
      cfg_wb_addr   = addr;
      cfg_blocknum  = 16'(nblk);
      cfg_start     = 1'b1;
      tick(1);
      cfg_start     = 1'b0;
      src_left      = nbeats;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         tick(1);
         n++;
      end
      check_eq("done", val_t'(done), val_t'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_in_ready"}, val_t'(in_ready), val_t'(0));
      check_eq({tag, "_mwrite"}, val_t'(wr_mwrite), val_t'(0));
      check_eq({tag, "_mvalid"}, val_t'(wr_mvalid), val_t'(0));
      check_eq({tag, "_mlast"}, val_t'(wr_mlast), val_t'(0));
      check_eq({tag, "_done"}, val_t'(done), val_t'(0));
      check_eq({tag, "_err"}, val_t'(err), val_t'(0));
      check_eq({tag, "_maddr"}, val_t'(wr_maddr), val_t'(0));
      check_eq({tag, "_state"}, val_t'(dbg_state), val_t'(0));
   endtask

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog got timeout want finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int n;
      #1 axi_rst = 1'b1;
      tick(3);
      check_reset_outputs("rst");
      axi_rst = 1'b0;
      tick(2);

      // zero blocks: done two cycles after start, no address request
      exp_addr_q.delete();
      start_run(64'h0, 0, 0, -1);
      check_eq("blk0_done_early", val_t'(done), val_t'(0));
      tick(1);
      check_eq("blk0_done", val_t'(done), val_t'(1));
      tick(5);
      check_eq("blk0_no_mwrite", val_t'(mwrite_cycles), val_t'(0));

      // two blocks at 0x1000, full-rate sink
      rdy_mode = 1;
      acc_delay = 0;
      exp_addr_q = '{64'h1000, 64'h1800};
      start_run(64'h1000, 2, 64, -1);
      wait_done(2000);
      check_eq("t2_beats", val_t'(beats_seen), val_t'(64));
      check_eq("t2_bursts", val_t'(bursts_seen), val_t'(2));
      check_eq("t2_exp_empty", val_t'(exp_q.size()), val_t'(0));
      check_eq("t2_addr_used", val_t'(exp_addr_q.size()), val_t'(0));
      check_eq("t2_err", val_t'(err), val_t'(0));

      // unaligned base, slow address accept, random write-ready
      rdy_mode = 2;
      acc_delay = 10;
      exp_addr_q = '{64'h1_2345_6800, 64'h1_2345_7000, 64'h1_2345_7800};
      start_run(64'h1_2345_6F00, 3, 96, -1);
      wait_done(5000);
      check_eq("t3_beats", val_t'(beats_seen), val_t'(96));
      check_eq("t3_exp_empty", val_t'(exp_q.size()), val_t'(0));
      check_eq("t3_addr_used", val_t'(exp_addr_q.size()), val_t'(0));

      // backpressure: 100 beats offered while the sink stalls
      rdy_mode = 0;
      acc_delay = 0;
      exp_addr_q = '{64'h4000, 64'h4800};
      start_run(64'h4000, 2, 100, -1);
      n = 0;
      while (accepted_cnt < 64 && n < 500) begin
         tick(1);
         n++;
      end
      tick(10);
      check_eq("t4_fill_cnt", val_t'(accepted_cnt), val_t'(64));
      check_eq("t4_in_ready_full", val_t'(in_ready), val_t'(0));
      check_eq("t4_mvalid_stalled", val_t'(wr_mvalid), val_t'(1));
      rdy_mode = 1;
      wait_done(3000);
      check_eq("t4_all_accepted", val_t'(accepted_cnt), val_t'(100));
      check_eq("t4_beats", val_t'(beats_seen), val_t'(64));
      check_eq("t4_leftover", val_t'(exp_q.size()), val_t'(36));

      // error response on the second burst
      acc_delay = 2;
      bad_resp = 2'b10;
      exp_addr_q = '{64'h8000, 64'h8800};
      start_run(64'h8000, 2, 64, 1);
      wait_done(2000);
      check_eq("t5_err", val_t'(err), val_t'(1));
      tick(3);
      check_eq("t5_err_sticky", val_t'(err), val_t'(1));
      check_eq("t5_beats", val_t'(beats_seen), val_t'(64));
      exp_addr_q.delete();
      start_run(64'h0, 0, 0, -1);
      check_eq("t5_err_cleared", val_t'(err), val_t'(0));
      check_eq("t5_done_cleared", val_t'(done), val_t'(0));
      tick(1);
      check_eq("t5_done_again", val_t'(done), val_t'(1));

      // reset during DATA, then a clean single-block run
      rdy_mode = 0;
      acc_delay = 0;
      exp_addr_q = '{64'hA000};
      start_run(64'hA000, 1, 32, -1);
      n = 0;
      while (!wr_mvalid && n < 300) begin
         tick(1);
         n++;
      end
      check_eq("t6_in_data", val_t'(wr_mvalid), val_t'(1));
      tick(2);
      axi_rst = 1'b1;
      src_left = 0;
      #1;
      check_reset_outputs("t6_rst");
      tick(2);
      axi_rst = 1'b0;
      tick(2);
      rdy_mode = 1;
      exp_addr_q = '{64'hA000};
      start_run(64'hA000, 1, 32, -1);
      wait_done(2000);
      check_eq("t6_beats", val_t'(beats_seen), val_t'(32));
      check_eq("t6_bursts", val_t'(bursts_seen), val_t'(1));
      check_eq("t6_exp_empty", val_t'(exp_q.size()), val_t'(0));
      check_eq("t6_err", val_t'(err), val_t'(0));

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
